// File: rtl/forth_boot_ctrl.sv
// forth_boot_ctrl: holds the forth core in reset while a framed, checksummed
// program image streams into imem, then releases the core on a checksum match.
module forth_boot_ctrl #(
    parameter int IADDR_W = 10,
    parameter int WORD_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_in_valid,
    input  logic [WORD_W-1:0]  i_in_data,
    output logic               o_in_ready,
    input  logic               i_reboot,
    output logic               o_imem_we,
    output logic [IADDR_W-1:0] o_imem_waddr,
    output logic [WORD_W-1:0]  o_imem_wdata,
    output logic               o_core_reset,
    output logic               o_boot_done,
    output logic               o_boot_err
);
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_CSUM, S_RUN, S_ERR} state_t;
    localparam longint unsigned MAX_N = 64'd1 << IADDR_W;

    state_t             r_state, w_state_nx;
    logic [IADDR_W:0]   r_rem, w_rem_nx;
    logic [IADDR_W-1:0] r_addr, w_addr_nx;
    logic [WORD_W-1:0]  r_sum, w_sum_nx;
    logic               r_we, w_wr, w_acc, w_big;
    logic [IADDR_W-1:0] r_waddr;
    logic [WORD_W-1:0]  r_wdata;

    assign o_in_ready   = ~i_reset & (r_state != S_RUN);
    assign w_acc        = i_in_valid & o_in_ready;
    assign w_big        = 64'(i_in_data) > MAX_N;
    assign o_imem_we    = r_we;
    assign o_imem_waddr = r_waddr;
    assign o_imem_wdata = r_wdata;
    assign o_core_reset = r_state != S_RUN;
    assign o_boot_done  = r_state == S_RUN;
    assign o_boot_err   = r_state == S_ERR;

    // ERR accepts the next word as a fresh header, so it shares the HDR branch
    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_rem;
        w_addr_nx  = r_addr;
        w_sum_nx   = r_sum;
        w_wr       = 1'b0;
        case (r_state)
            S_HDR, S_ERR: if (w_acc) begin
                w_state_nx = w_big ? S_ERR : (i_in_data == '0 ? S_CSUM : S_LOAD);
                w_rem_nx   = i_in_data[IADDR_W:0];
                w_addr_nx  = '0;
                w_sum_nx   = '0;
            end
            S_LOAD: if (w_acc) begin
                w_wr       = 1'b1;
                w_sum_nx   = r_sum + i_in_data;
                w_addr_nx  = r_addr + IADDR_W'(1);
                w_rem_nx   = r_rem - (IADDR_W+1)'(1);
                w_state_nx = (r_rem == (IADDR_W+1)'(1)) ? S_CSUM : S_LOAD;
            end
            S_CSUM: if (w_acc) w_state_nx = (i_in_data == r_sum) ? S_RUN : S_ERR;
            S_RUN: if (i_reboot) begin
                w_state_nx = S_HDR;
                w_rem_nx   = '0;
                w_addr_nx  = '0;
                w_sum_nx   = '0;
            end
            default: w_state_nx = S_HDR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_HDR;
            r_rem   <= '0;
            r_addr  <= '0;
            r_sum   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nx;
            r_rem   <= w_rem_nx;
            r_addr  <= w_addr_nx;
            r_sum   <= w_sum_nx;
            r_we    <= w_wr;
            if (w_wr) begin
                r_waddr <= r_addr;
                r_wdata <= i_in_data;
            end
        end
    end
endmodule

// File: tb/tb_forth_boot_ctrl.sv
// tb_forth_boot_ctrl: vector table, timed hand sequences and random gapped
// frames checked against a frame-level model of the boot loader.
module tb_forth_boot_ctrl;
    logic        clk = 1'b0;
    logic        rst, vld, reb;
    logic [15:0] din;
    logic        rdy, we, core_rst, done, err;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    int          total = 0;
    int          bad = 0;
    logic [25:0] wq[$];

    typedef struct {
        logic [15:0] w[6];
        int          len;
        bit          e_done;
        bit          e_err;
        int          e_wr;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    forth_boot_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_in_valid(vld), .i_in_data(din),
        .o_in_ready(rdy), .i_reboot(reb), .o_imem_we(we), .o_imem_waddr(waddr),
        .o_imem_wdata(wdata), .o_core_reset(core_rst), .o_boot_done(done),
        .o_boot_err(err)
    );

    always @(negedge clk) if (we === 1'b1) wq.push_back({waddr, wdata});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1; vld = 0; reb = 0; din = '0;
        tick;
        chk("rst_ready", rdy, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_core_reset", core_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 0;
        #1;
        chk("post_rst_ready", rdy, 1);
        wq.delete();
    endtask

    task automatic do_reboot;
        reb = 1;
        tick;
        reb = 0;
        chk("reboot_core_reset", core_rst, 1);
        chk("reboot_done", done, 0);
        chk("reboot_ready", rdy, 1);
        chk("reboot_err", err, 0);
    endtask

    // Model: frame = N, N payload words, checksum; writes go to 0..N-1.
    task automatic run_frame(input logic [15:0] fr[$], input bit gap, input bit rb);
        int n, idx, guard, s, m;
        bit big, ok, acc;
        logic [25:0] ew[$];
        n = int'(fr[0]);
        big = n > 1024;
        s = 0;
        if (!big) for (int i = 0; i < n; i++) begin
            ew.push_back({10'(i), fr[1+i]});
            s = (s + int'(fr[1+i])) % 65536;
        end
        ok = !big && (int'(fr[n+1]) == s);
        wq.delete();
        idx = 0;
        guard = 0;
        while (idx < fr.size() && guard < 20000) begin
            vld = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            din = vld ? fr[idx] : 16'($urandom);
            reb = rb;
            acc = vld && rdy;
            if (acc && idx == fr.size() - 1) begin
                chk("pre_done", done, 0);
                chk("pre_core_reset", core_rst, 1);
            end
            tick;
            guard++;
            if (acc) begin
                idx++;
                if (idx == 1) chk("hdr_err", err, {31'b0, big});
            end
        end
        vld = 0;
        reb = 0;
        if (idx < fr.size()) chk("frame_timeout", idx, fr.size());
        chk("done", done, {31'b0, ok});
        chk("core_reset", core_rst, {31'b0, !ok});
        chk("err", err, {31'b0, !ok});
        chk("ready", rdy, {31'b0, !ok});
        @(negedge clk);
        #1;
        chk("wr_count", wq.size(), ew.size());
        m = wq.size() < ew.size() ? wq.size() : ew.size();
        for (int i = 0; i < m; i++) chk("wr", {6'b0, wq[i]}, {6'b0, ew[i]});
    endtask

    task automatic set_vec(input int k, input logic [15:0] a, b, c, d, e, f,
                           input int len, input bit dn, input bit er, input int nw);
        tbl[k].w[0] = a; tbl[k].w[1] = b; tbl[k].w[2] = c;
        tbl[k].w[3] = d; tbl[k].w[4] = e; tbl[k].w[5] = f;
        tbl[k].len = len; tbl[k].e_done = dn; tbl[k].e_err = er; tbl[k].e_wr = nw;
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] bw[5];
        int s, n;
        rst = 1; vld = 0; reb = 0; din = '0;
        set_vec(0, 16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00A, 0, 5, 1, 0, 3);
        set_vec(1, 16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00B, 0, 5, 0, 1, 3);
        set_vec(2, 16'h0, 16'h0, 0, 0, 0, 0, 2, 1, 0, 0);
        set_vec(3, 16'h0, 16'h5, 0, 0, 0, 0, 2, 0, 1, 0);
        set_vec(4, 16'h0401, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        set_vec(5, 16'h1, 16'h1234, 16'h1234, 0, 0, 0, 3, 1, 0, 1);
        set_vec(6, 16'h2, 16'hFFFF, 16'h0002, 16'h0001, 0, 0, 4, 1, 0, 2);
        set_vec(7, 16'hFFFF, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            do_reset;
            q.delete();
            for (int i = 0; i < tbl[k].len; i++) q.push_back(tbl[k].w[i]);
            run_frame(q, 0, 0);
            chk("tbl_done", done, {31'b0, tbl[k].e_done});
            chk("tbl_err", err, {31'b0, tbl[k].e_err});
            chk("tbl_wr", wq.size(), tbl[k].e_wr);
        end

        // Cycle-exact basic boot, then idle in RUN and a reboot pulse
        do_reset;
        bw = '{16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00A};
        for (int k = 0; k < 5; k++) begin
            vld = 1; din = bw[k];
            tick;
            chk("basic_we", we, {31'b0, k >= 1 && k <= 3});
            if (k >= 1 && k <= 3) begin
                chk("basic_waddr", waddr, k - 1);
                chk("basic_wdata", wdata, bw[k]);
            end
        end
        chk("basic_done", done, 1);
        chk("basic_core_reset", core_rst, 0);
        chk("basic_ready", rdy, 0);
        din = 16'h5555;
        tick;
        chk("run_hold_done", done, 1);
        chk("run_hold_we", we, 0);
        vld = 0;
        do_reboot;
        tick;
        chk("hdr_idle_done", done, 0);

        // Bad checksum, then a good frame out of ERR
        do_reset;
        run_frame('{16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00B}, 0, 0);
        run_frame('{16'h1, 16'h1234, 16'h1234}, 0, 0);

        // Reset after two payload words of a three-word frame
        do_reset;
        bw = '{16'h3, 16'h1, 16'h2, 16'h0, 16'h0};
        for (int k = 0; k < 3; k++) begin
            vld = 1; din = bw[k];
            tick;
        end
        do_reset;
        run_frame('{16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00A}, 0, 0);

        // Reboot held high while loading is ignored
        do_reset;
        run_frame('{16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00A}, 0, 1);
        do_reboot;

        // Gapped basic frame
        for (int r = 0; r < 3; r++) begin
            run_frame('{16'h3, 16'h1, 16'h2, 16'hE007, 16'hE00A}, 1, 0);
            do_reboot;
        end

        // Maximal image of 1024 words
        q.delete();
        q.push_back(16'h0400);
        s = 0;
        for (int i = 0; i < 1024; i++) begin
            q.push_back(16'($urandom));
            s = (s + int'(q[$])) % 65536;
        end
        q.push_back(16'(s));
        run_frame(q, 0, 0);
        do_reboot;

        // Random frames with random gaps, checksum errors and reboot noise
        for (int r = 0; r < 30; r++) begin
            if (done === 1'b1) do_reboot;
            n = $urandom_range(0, 8);
            q.delete();
            q.push_back(16'(n));
            s = 0;
            for (int i = 0; i < n; i++) begin
                q.push_back(16'($urandom));
                s = (s + int'(q[$])) % 65536;
            end
            q.push_back($urandom_range(0, 1) ? 16'(s) : 16'(s) ^ 16'($urandom_range(1, 65535)));
            run_frame(q, 1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/forth_boot_ctrl.md
# forth_boot_ctrl

Boot sequencer for the forth core's instruction memory. It holds the core in reset and accepts a framed program image from a host word stream using a valid/ready handshake. It writes the image into the instruction RAM and checks a 16-bit additive checksum. On a match it releases the core. It sits between the host loader link, the imem write port and the core's `reset` input.

## Interface
- `IADDR_W`, default 10: instruction address width; maximum image is 2^IADDR_W words.
- `WORD_W`, default 16: instruction and stream word width.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  host word valid.
- `in_data`  in  WORD_W  host word.
- `in_ready`  out  1  block can accept a word.
- `reboot`  in  1  return from RUN to loading (ignored in other states).
- `imem_we`  out  1  imem write strobe.
- `imem_waddr`  out  IADDR_W  imem write address.
- `imem_wdata`  out  WORD_W  imem write data.
- `core_reset`  out  1  drives the forth core's `reset`.
- `boot_done`  out  1  image loaded and verified; core running.
- `boot_err`  out  1  last image was rejected.

## Operation
- Accept = `in_valid & in_ready`. A word is consumed only on accept. `in_data` is don't-care otherwise.
- Frame format: header word N (payload length), then N payload words, then one checksum word. The checksum word equals the sum of the payload words, truncated to WORD_W bits.
- States:
  - HDR: `in_ready`=1. On accept of N:
    - N > 2^IADDR_W → ERR.
    - N == 0 → CSUM.
    - Otherwise → LOAD; remaining count = N, address = 0, sum = 0.
  - LOAD: `in_ready`=1. On each accept:
    - Register a write of the word to the current address.
    - Add the word to sum; increment address; decrement remaining.
    - When the word accepted is the last one (remaining == 1), go to CSUM.
  - CSUM: `in_ready`=1. On accept:
    - word == sum → RUN.
    - Otherwise → ERR.
  - RUN: `in_ready`=0, `core_reset`=0, `boot_done`=1. `reboot`=1 → HDR; counters are cleared.
  - ERR: `boot_err`=1, `in_ready`=1. The next accepted word is treated as a header, exactly as in HDR. `boot_err` clears in the cycle after that header is accepted.
- The remaining-count register is IADDR_W+1 bits wide so that N = 2^IADDR_W is representable. Address wraps only in that maximal case, after the final write.
- `core_reset`=1 in every state except RUN.
- Imem contents are never cleared. A rejected or interrupted image leaves partially written words in place.
- `reboot` in HDR, LOAD, CSUM or ERR has no effect.

## Timing
- Reset values:
  - `in_ready`=0 during the reset cycle, then 1 (state HDR).
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `core_reset`=1, `boot_done`=0, `boot_err`=0.
- Write latency: a payload word accepted in cycle t appears on `imem_we`/`imem_waddr`/`imem_wdata` in cycle t+1, for exactly one cycle.
- Release timing:
  - Checksum match accepted in cycle t → `core_reset`=0 and `boot_done`=1 from cycle t+1.
  - The last imem write (at the latest in cycle t) is therefore always complete before release.
- Mismatch or oversize header accepted in cycle t → `boot_err`=1 from t+1.
- `reboot` sampled high in RUN in cycle t → `core_reset`=1, `boot_done`=0 and `in_ready`=1 from t+1.
- Throughput is one word per cycle, with no bubbles between header, payload and checksum.
- `reset` overrides everything, including mid-frame and in RUN:
  - Next cycle all outputs take their reset values.
  - Any pending write in that cycle is dropped.
- `in_valid` low in any state: state, counters and sum hold.

## Test plan
- Basic boot, `in_valid` held high: stream 0x0003, 0x0001, 0x0002, 0xE007, 0xE00A.
  - Writes of addr 0/1/2 with data 0x0001/0x0002/0xE007 in cycles 2-4 after header accept.
  - `core_reset` falls and `boot_done` rises in cycle 5.
  - `in_ready`=0 thereafter.
- Bad checksum: same payload with checksum 0xE00B.
  - `boot_err`=1; `core_reset` stays 1.
  - A following correct frame (0x0001, 0x1234, 0x1234) clears `boot_err` after its header and ends with `boot_done`=1.
- Gapped stream: `in_valid` toggled randomly during the basic frame.
  - Identical write sequence and addresses; no write on idle cycles.
  - Release occurs one cycle after checksum accept.
- Boundaries:
  - Header 0x0000 then checksum 0x0000 → RUN with no imem writes.
  - Header 0x0401 (N > 1024) → ERR immediately.
  - Header 0x0400 → 1024 writes to addresses 0..1023, then checksum phase.
- Reboot and reset:
  - In RUN, pulse `reboot` for one cycle → `core_reset`=1, `boot_done`=0, state HDR next cycle.
  - Assert `reset` after 2 payload words of a 3-word frame → all outputs at reset values next cycle; a fresh full frame then boots normally.
- `reboot` asserted during LOAD is ignored: the frame completes and boots normally.
